lpc_autocorr: RTL and testbench

//   Streaming autocorrelation front end of the LPC Levinson-Durbin recursion.
//   - Accepts one frame of FRAME_LEN signed samples and computes r[0..ORDER].
//   - Scales each lag and emits it serially to the Levinson stage on a valid/ready port.
//   - Its r output is the r operand of the error-update path; r[0] seeds the initial error.

---
 rtl/lpc_autocorr.sv | 195 +++++++++++++++++++
 tb/tb_lpc_autocorr.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_autocorr.sv
// -----------------------------------------------------------------------------
// lpc_autocorr
//   Streaming autocorrelation front end for an LPC Levinson-Durbin stage.
//   The block takes one frame of FRAME_LEN signed samples and computes
//   r[k] = sum_n x[n]*x[n-k] for k = 0..ORDER. It then arithmetic-shifts each
//   lag right by OUT_SHIFT and sends the lags serially on a valid/ready port.
//   r[0] comes first, because the Levinson stage uses it to seed its error term.
//
//   Build option (compile-time macro):
//     LPC_AC_SAT_EN  - defined  : clamp each shifted lag to the signed 32-bit range
//                      undefined: send the low 32 bits of the shifted lag (wrap)
//
// Ports
//   clk      in   1        rising-edge clock
//   rst_n    in   1        synchronous active-low reset
//   s_data   in   DATA_W   signed input sample
//   s_valid  in   1        sample valid
//   s_ready  out  1        sample ready (high only while accumulating)
//   r_data   out  32       signed scaled lag value
//   r_idx    out  clog2    lag index of r_data
//   r_last   out  1        high together with r_idx == ORDER
//   r_valid  out  1        lag valid
//   r_ready  in   1        lag accepted downstream
//   busy     out  1        high from first accepted sample to last accepted lag
// -----------------------------------------------------------------------------
module lpc_autocorr #(
    parameter int DATA_W    = 16,
    parameter int ORDER     = 10,
    parameter int FRAME_LEN = 256,
    parameter int OUT_SHIFT = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic signed [DATA_W-1:0]         s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic signed [31:0]               r_data,
    output logic [$clog2(ORDER+1)-1:0]       r_idx,
    output logic                             r_last,
    output logic                             r_valid,
    input  logic                             r_ready,
    output logic                             busy
);

    localparam int IDX_W = $clog2(ORDER + 1);
    localparam int ACC_W = 2 * DATA_W + $clog2(FRAME_LEN) + 1;
    localparam int PRD_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    logic [CNT_W-1:0]           r_cnt;
    logic [IDX_W-1:0]           r_lag_idx;
    logic                       r_busy;
    logic signed [DATA_W-1:0]   r_dly [1:ORDER];
    logic signed [ACC_W-1:0]    r_acc [0:ORDER];

    logic signed [DATA_W-1:0]   w_tap  [0:ORDER];
    logic signed [PRD_W-1:0]    w_prod [0:ORDER];
    logic signed [ACC_W-1:0]    w_acc_sel;
    logic signed [31:0]         w_out;
    logic                       w_accept;
    logic                       w_lag_hs;
    logic                       w_frame_done;
    logic                       w_last_sample;

    assign w_accept      = s_valid && s_ready;
    assign w_lag_hs      = r_valid && r_ready;
    assign w_frame_done  = w_lag_hs && (r_lag_idx == IDX_W'(ORDER));
    assign w_last_sample = w_accept && (r_cnt == CNT_W'(FRAME_LEN - 1));

    // Tap 0 is the incoming sample itself, so r[0] is the energy term.
    // Taps 1..ORDER come from the delay line.
    assign w_tap[0] = s_data;
    generate
        for (genvar gi = 1; gi <= ORDER; gi++) begin : g_tap
            assign w_tap[gi] = r_dly[gi];
        end
        for (genvar gi = 0; gi <= ORDER; gi++) begin : g_prod
            assign w_prod[gi] = s_data * w_tap[gi];
        end
    endgenerate

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        r_valid      = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                s_ready = 1'b1;
                if (w_last_sample) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                r_valid = 1'b1;
                if (w_frame_done) begin
                    w_state_next = ST_ACCUM;
                end
            end
            default: w_state_next = ST_ACCUM;
        endcase
    end

    // ------------------------------------------------ datapath registers
    // The delay line, accumulators and counter clear at the end of each
    // frame. The first ORDER samples of a frame therefore see zeros in place
    // of samples from the previous frame.
    always_ff @(posedge clk) begin
        if (!rst_n || w_frame_done) begin
            r_cnt <= '0;
            for (int k = 1; k <= ORDER; k++) begin
                r_dly[k] <= '0;
            end
            for (int k = 0; k <= ORDER; k++) begin
                r_acc[k] <= '0;
            end
        end else if (w_accept) begin
            r_cnt    <= r_cnt + 1'b1;
            r_dly[1] <= s_data;
            for (int k = 2; k <= ORDER; k++) begin
                r_dly[k] <= r_dly[k-1];
            end
            for (int k = 0; k <= ORDER; k++) begin
                r_acc[k] <= r_acc[k] + {{(ACC_W-PRD_W){w_prod[k][PRD_W-1]}}, w_prod[k]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_frame_done) begin
            r_lag_idx <= '0;
        end else if (w_lag_hs) begin
            r_lag_idx <= r_lag_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_frame_done) begin
            r_busy <= 1'b0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
        end
    end

    // ------------------------------------------------------ output path
    always_comb begin
        w_acc_sel = '0;
        for (int k = 0; k <= ORDER; k++) begin
            if (r_lag_idx == IDX_W'(k)) begin
                w_acc_sel = r_acc[k];
            end
        end
    end

`ifdef LPC_AC_SAT_EN
    logic signed [ACC_W-1:0] w_shifted;
    assign w_shifted = w_acc_sel >>> OUT_SHIFT;

    // The value fits in 32 bits only when every bit from bit 31 up matches the sign bit.
    always_comb begin
        if (&w_shifted[ACC_W-1:31] || ~|w_shifted[ACC_W-1:31]) begin
            w_out = w_shifted[31:0];
        end else if (w_shifted[ACC_W-1]) begin
            w_out = 32'sh8000_0000;
        end else begin
            w_out = 32'sh7FFF_FFFF;
        end
    end
`else
    assign w_out = 32'(w_acc_sel >>> OUT_SHIFT);
`endif

    // Lag fields read as zero outside DRAIN, so reset and idle show 0.
    assign r_data = r_valid ? w_out : 32'sd0;
    assign r_idx  = r_lag_idx;
    assign r_last = r_valid && (r_lag_idx == IDX_W'(ORDER));
    assign busy   = r_busy;

endmodule

// File: tb/tb_lpc_autocorr.sv
// -----------------------------------------------------------------------------
// tb_lpc_autocorr
//   Scoreboard bench for lpc_autocorr. The stimulus process pushes the
//   hand-derived lags of each frame into a queue as the frame starts. A
//   separate monitor pops and compares one entry for every lag the DUT
//   presents, and it also drives r_ready, including one backpressure stall.
//   A second instance with OUT_SHIFT=0 is fed -32768 continuously to exercise
//   accumulator overflow into 32 bits.
// -----------------------------------------------------------------------------
module tb_lpc_autocorr;

    localparam int ORDER = 10;

    typedef struct {
        int               idx;
        logic signed [31:0] data;
        bit               last;
    } lag_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic signed [31:0] r_data;
    logic [3:0]         r_idx;
    logic               r_last;
    logic               r_valid;
    logic               r_ready;
    logic               busy;

    logic               o_rst_n;
    logic signed [15:0] o_s_data;
    logic               o_s_valid;
    logic               o_s_ready;
    logic signed [31:0] o_r_data;
    logic [3:0]         o_r_idx;
    logic               o_r_last;
    logic               o_r_valid;
    logic               o_r_ready;
    logic               o_busy;

    always #5 clk = ~clk;

    lpc_autocorr #(.DATA_W(16), .ORDER(ORDER), .FRAME_LEN(256), .OUT_SHIFT(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .r_data(r_data), .r_idx(r_idx), .r_last(r_last), .r_valid(r_valid),
        .r_ready(r_ready), .busy(busy)
    );

    lpc_autocorr #(.DATA_W(16), .ORDER(ORDER), .FRAME_LEN(256), .OUT_SHIFT(0)) dut_ovf (
        .clk(clk), .rst_n(o_rst_n), .s_data(o_s_data), .s_valid(o_s_valid), .s_ready(o_s_ready),
        .r_data(o_r_data), .r_idx(o_r_idx), .r_last(o_r_last), .r_valid(o_r_valid),
        .r_ready(o_r_ready), .busy(o_busy)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    lag_t exp_q[$];
    bit   mon_off   = 1'b0;
    bit   bp_active = 1'b0;
    int   stall_cnt = 0;
    bit   ovf_done  = 1'b0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Stimulus patterns: 0 constant 16, 1 impulse, 2 alternating +/-16, 3 filler.
    function automatic logic signed [15:0] sample(input int pat, input int i);
        case (pat)
            0:       return 16'sd16;
            1:       return (i == 0) ? 16'sd16384 : 16'sd0;
            2:       return (i % 2 == 0) ? 16'sd16 : -16'sd16;
            default: return 16'sd5;
        endcase
    endfunction

    // Closed forms worked out by hand for 256-sample frames and OUT_SHIFT=8.
    //   constant 16 : 256*(256-k) >> 8              = 256-k
    //   impulse     : 16384^2 >> 8                  = 1048576 at k=0, else 0
    //   alternating : (-1)^k * 256*(256-k) >> 8     = (-1)^k * (256-k)
    function automatic logic signed [31:0] expv(input int pat, input int k);
        case (pat)
            0:       return 32'(256 - k);
            1:       return (k == 0) ? 32'sd1048576 : 32'sd0;
            default: return (k % 2 == 0) ? 32'(256 - k) : -32'(256 - k);
        endcase
    endfunction

    task automatic send_frame(input int pat, input int n, input bit push);
        int guard;
        if (push) begin
            for (int k = 0; k <= ORDER; k++) begin
                lag_t e;
                e.idx  = k;
                e.data = expv(pat, k);
                e.last = (k == ORDER);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < n; i++) begin
            s_data  = sample(pat, i);
            s_valid = 1'b1;
            guard   = 0;
            while (!s_ready && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 1000) begin
                chk(1'b0, "s_ready_timeout", 0, 1);
                i = n;
            end else begin
                @(negedge clk);
                if (i == 0) chk(busy == 1'b1, "busy_after_first", busy, 1);
            end
        end
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic wait_drained();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: decides r_ready for the next edge and checks what the DUT shows.
    initial begin : monitor
        logic signed [31:0] held;
        r_ready = 1'b1;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst_n && r_valid && !mon_off) begin
                chk(s_ready == 1'b0, "s_ready_low_in_drain", s_ready, 0);
                if (bp_active && r_idx == 4'd3 && stall_cnt < 5) begin
                    if (stall_cnt > 0) chk(r_data == held, "stall_data_stable", r_data, held);
                    held    = r_data;
                    r_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    r_ready = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_lag", r_idx, -1);
                    end else begin
                        lag_t e;
                        e = exp_q.pop_front();
                        $display("lag idx=%0d data=%0d last=%0b (exp idx=%0d data=%0d last=%0b)",
                                 r_idx, r_data, r_last, e.idx, e.data, e.last);
                        chk(int'(r_idx) == e.idx, "lag_idx", r_idx, e.idx);
                        chk(r_data == e.data, "lag_data", r_data, e.data);
                        chk(r_last == e.last, "lag_last", r_last, e.last);
                    end
                end
            end else begin
                r_ready = 1'b1;
            end
        end
    end

    // Overflow instance: 256 samples of -32768 give r[0] = 2^38 and r[1] = 255*2^30.
    initial begin : ovf_run
        int guard;
        logic signed [31:0] e0, e1;
`ifdef LPC_AC_SAT_EN
        e0 = 32'sh7FFF_FFFF;
        e1 = 32'sh7FFF_FFFF;
`else
        e0 = 32'sh0000_0000;
        e1 = 32'shC000_0000;
`endif
        o_rst_n   = 1'b0;
        o_s_data  = -16'sd32768;
        o_s_valid = 1'b1;
        o_r_ready = 1'b1;
        repeat (3) @(negedge clk);
        o_rst_n = 1'b1;
        guard = 0;
        while (!o_r_valid && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk(o_r_valid && o_r_idx == 4'd0, "ovf_first_lag_idx0", o_r_idx, 0);
        chk(o_r_data == e0, "ovf_r0", o_r_data, e0);
        @(negedge clk);
        chk(o_r_idx == 4'd1, "ovf_second_lag_idx1", o_r_idx, 1);
        chk(o_r_data == e1, "ovf_r1", o_r_data, e1);
        ovf_done = 1'b1;
    end

    initial begin : stim
        int guard;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(negedge clk);
        chk(s_ready == 1'b1, "reset_s_ready", s_ready, 1);
        chk(r_valid == 1'b0, "reset_r_valid", r_valid, 0);
        chk(r_data == 32'sd0, "reset_r_data", r_data, 0);
        chk(r_idx == 4'd0, "reset_r_idx", r_idx, 0);
        chk(r_last == 1'b0, "reset_r_last", r_last, 0);
        chk(busy == 1'b0, "reset_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Constant frame with a 5-cycle stall at lag 3. The next frame's first
        // sample is held on s_valid during drain and must not be taken early.
        stall_cnt = 0;
        bp_active = 1'b1;
        send_frame(0, 256, 1'b1);
        send_frame(0, 256, 1'b1);
        wait_drained();
        bp_active = 1'b0;
        chk(stall_cnt == 5, "stall_cycles", stall_cnt, 5);

        send_frame(1, 256, 1'b1);   // impulse
        send_frame(2, 256, 1'b1);   // alternating
        wait_drained();

        // Reset after 100 samples; the next full frame must be unaffected.
        send_frame(3, 100, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk(busy == 1'b0, "midframe_reset_busy", busy, 0);
        rst_n = 1'b1;
        send_frame(0, 256, 1'b1);
        wait_drained();

        // Reset during drain: r_valid must be gone on the next cycle.
        mon_off = 1'b1;
        send_frame(0, 256, 1'b0);
        guard = 0;
        while (!r_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk(r_valid == 1'b1, "drain_entered", r_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk(r_valid == 1'b0, "drain_reset_r_valid", r_valid, 0);
        chk(s_ready == 1'b1, "drain_reset_s_ready", s_ready, 1);
        rst_n   = 1'b1;
        mon_off = 1'b0;
        @(negedge clk);

        guard = 0;
        while (!ovf_done && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk(ovf_done == 1'b1, "ovf_completed", ovf_done, 1);
        repeat (5) @(negedge clk);
        chk(exp_q.size() == 0, "final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
